inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Instruction fetch stage with prefetch buffering, placed directly upstream of the IF/ID pipeline register. It issues word fetches to the unified memory port over a request/grant/response handshake and tracks outstanding requests. Returned words go into a small in-order queue that the decode side drains through a valid/ready handshake. A branch/jump redirect flushes the queue, discards in-flight responses and restarts fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- MAX_OUT, 2: maximum outstanding memory requests, ≤DEPTH.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  word-aligned fetch address (bits [1:0] = 0).
- mem_gnt  in  1  memory accepts the request this cycle (mem_req & mem_gnt = accepted).
- mem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- mem_rdata  in  32  response word.
- redirect  in  1  flush and restart fetch (taken branch, jump, trap).
- redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  IF/ID accepts the head (low = stall).
- out_inst  out  32  head instruction; 32'h0000_0033 (NOP) when out_valid=0.
- out_pc  out  32  PC of head instruction; 0 when out_valid=0.

## Operation
- State: fetch_pc, queue (DEPTH × {pc, inst}), count, outstanding, discard.
- Issue: mem_req = ~rst & ~redirect & (count + outstanding < DEPTH) & (outstanding < MAX_OUT). mem_addr = fetch_pc.
- On accept: fetch_pc += 4, and that request's PC is pushed into a pending-PC FIFO (depth MAX_OUT).
- Response: if discard > 0, drop the word and decrement discard. Otherwise push {pending pc, mem_rdata} into the queue. The pending-PC entry pops in both cases.
- outstanding_next = outstanding + accept − rvalid.
- Pop: the head is removed when out_valid & out_ready.
- Push and pop in the same cycle is legal at any count. The credit rule guarantees a push never overflows the queue.
- Redirect (highest priority) takes effect at the end of the cycle in which it is sampled:
  - queue emptied;
  - fetch_pc ← redirect_pc;
  - discard ← outstanding_next;
  - pending-PC FIFO contents are kept only for discard bookkeeping.
- A response arriving in the redirect cycle is dropped. A pop in the redirect cycle is still honoured (the head was valid that cycle).
- Redirect while discard > 0: discard ← outstanding_next again. No double counting, since discard ≤ outstanding always holds.
- fetch_pc wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, out_valid=0, out_inst=32'h0000_0033, out_pc=0, count=outstanding=discard=0.
- rst asserted mid-operation: all state returns to the reset values at the next edge. Responses to requests issued before reset are ignored, because outstanding is zeroed and rvalid with outstanding=0 is dropped.
- First request: the first cycle after rst deasserts, mem_addr=RESET_PC.
- Latency: an accept in cycle N with rvalid in N+1 gives out_valid in N+2. Redirect at N gives mem_req with redirect_pc at N+1.
- Throughput: one instruction per cycle sustained with a 1-cycle memory and MAX_OUT ≥ 2.
- Outputs mem_req/mem_addr are combinational from registers and redirect. out_* are pure register outputs.

## Structure
- RESET_PC default and the NOP encoding 32'h0000_0033 go in the shared defines.v as `RESET_PC` and `NOP_INST`.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, count). It is instantiated twice: the instruction queue (64-bit) and the pending-PC FIFO (32-bit).

## Test plan
- Reset release, memory with mem_gnt=1 and 1-cycle latency, out_ready=1 → addresses 0,4,8,… issued back-to-back; out_pc 0,4,8 appear from cycle 3 with one instruction per cycle.
- out_ready=0 for 10 cycles → exactly DEPTH=4 instructions buffered, mem_req drops and count holds at 4. Then out_ready=1 → PCs delivered in order with no gaps or duplicates.
- mem_gnt random 50% with latency 1–3 cycles → delivered PC stream strictly +4 and out_inst matches the memory image.
- redirect to 0x100 while 2 requests outstanding → both stale responses dropped; the next out_pc=0x100 and no pre-redirect PC appears afterwards.
- redirect and an rvalid in the same cycle, plus a second redirect to 0x200 two cycles later → only 0x200,0x204,… are delivered.
- fetch_pc=0xFFFF_FFF8 → issued addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Then rst pulsed mid-stream → out_valid=0, out_inst=0x33 and fetch resumes at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and payload types for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0033;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; storage is not reset.
module inst_fetch_queue_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching instruction fetch stage: issues word fetches, buffers returned
// words in order, and flushes/restarts on redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned OCW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0]  discard_q, discard_d;
    logic [OCW-1:0]  outstanding;
    logic [OCW-1:0]  outstanding_next;
    logic [QCW-1:0]  q_count;
    logic [XLEN-1:0] pend_pc;
    fetch_entry_t    q_head;
    fetch_entry_t    q_wdata;
    logic            credit_ok;
    logic            accept;
    logic            resp;
    logic            q_push;
    logic            q_pop;

    // Queue slots are reserved for every in-flight request, so a push never overflows.
    assign credit_ok = ((32'(q_count) + 32'(outstanding)) < 32'(DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUT));
    assign mem_req   = ~rst & ~redirect & credit_ok;
    assign mem_addr  = fetch_pc_q;

    assign accept  = mem_req & mem_gnt;
    assign resp    = mem_rvalid & (outstanding != '0);
    assign q_push  = resp & (discard_q == '0) & ~redirect;
    assign q_pop   = out_valid & out_ready;
    assign q_wdata = '{pc: pend_pc, inst: mem_rdata};

    always_comb begin
        outstanding_next = outstanding + OCW'(accept) - OCW'(resp);
        fetch_pc_d       = fetch_pc_q;
        discard_d        = discard_q;
        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (resp && (discard_q != '0)) discard_d = discard_q - OCW'(1);
        // Every response still owed at the redirect belongs to the old path.
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            discard_d  = outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    // PCs of accepted requests; its occupancy is the outstanding-request count.
    inst_fetch_queue_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pend_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (accept),
        .pop_i   (resp),
        .data_i  (fetch_pc_q),
        .data_o  (pend_pc),
        .count_o (outstanding)
    );

    inst_fetch_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  (q_wdata),
        .data_o  (q_head),
        .count_o (q_count)
    );

    assign out_valid = (q_count != '0);
    assign out_inst  = out_valid ? q_head.inst : NOP_INST;
    assign out_pc    = out_valid ? q_head.pc   : '0;

endmodule
